// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: opcode
// encodings, FSM state type, iteration-step mode and opcode classifiers.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MSUB  = 3'b101;
  localparam logic [2:0] OP_MTHI  = 3'b110;
  localparam logic [2:0] OP_MTLO  = 3'b111;

  // One iteration per operand bit; the unit is built for 32-bit operands.
  localparam int MULDIV_ITERS = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } step_mode_e;

  // Ops whose operands are two's complement and need magnitude/sign handling.
  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  // Ops that run the restoring-divide datapath instead of shift-add.
  function automatic logic op_is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between decode/execute (master) and the
// multiply/divide unit (slave).
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);

  logic             Start;
  logic [2:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Hi_res;
  logic [WIDTH-1:0] Lo_res;

  modport master (
    output Start, Op, A, B,
    input  Busy, Done, Hi_res, Lo_res
  );

  modport slave (
    input  Start, Op, A, B,
    output Busy, Done, Hi_res, Lo_res
  );

endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration of the multiply/divide datapath.
// The 2*WIDTH working value is {acc, shr}.
//   STEP_MUL: LSB-first shift-add; shr holds the remaining multiplier bits and
//             collects the low product bits as they shift in from acc.
//   STEP_DIV: restoring divide; {acc, shr} shifts left one bit, the divisor is
//             subtracted when it fits, and the quotient bit enters shr's LSB.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  step_mode_e       mode,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] shr_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] shr_o
);

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] sub_low;

  // Compute both candidate updates and select by mode.
  always_comb begin
    add_sum = {1'b0, acc_i} + {1'b0, opnd_i};
    rem_sh  = {acc_i, shr_i[WIDTH-1]};
    // Only the low bits matter: the subtract is used only when rem_sh >= opnd,
    // and then the difference is below opnd and fits in WIDTH bits.
    sub_low = rem_sh[WIDTH-1:0] - opnd_i;
    acc_o   = acc_i;
    shr_o   = shr_i;
    if (mode == STEP_DIV) begin
      if (rem_sh >= {1'b0, opnd_i}) begin
        acc_o = sub_low;
        shr_o = {shr_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = rem_sh[WIDTH-1:0];
        shr_o = {shr_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (shr_i[0]) begin
        acc_o = add_sum[WIDTH:1];
        shr_o = {add_sum[0], shr_i[WIDTH-1:1]};
      end else begin
        acc_o = {1'b0, acc_i[WIDTH-1:1]};
        shr_o = {acc_i[0], shr_i[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO pair.
// Iterative ops occupy the unit for 33 cycles (32 CALC iterations + FIX);
// MTHI/MTLO complete at the Start edge. HI/LO change only on a Done edge or
// reset.
// Optional feature: define MULDIV_MADD_EN to implement MADD/MSUB with the
// 64-bit accumulate adder; otherwise those opcodes complete as single-cycle
// no-ops.
module mul_div_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          Clk,
  input  logic          Rst_n,
  mul_div_unit_if.slave bus
);

  localparam int               CNT_W    = $clog2(MULDIV_ITERS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULDIV_ITERS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] shr_q, shr_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div0_q, div0_d;

  logic             start_signed;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;

  step_mode_e       step_mode;
  logic [WIDTH-1:0] step_acc, step_shr;

  logic [2*WIDTH-1:0] prod_mag, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
`ifdef MULDIV_MADD_EN
  logic [2*WIDTH-1:0] hilo_add, hilo_sub;
`endif

  assign step_mode = op_is_div(op_q) ? STEP_DIV : STEP_MUL;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode   (step_mode),
    .acc_i  (acc_q),
    .shr_i  (shr_q),
    .opnd_i (opnd_q),
    .acc_o  (step_acc),
    .shr_o  (step_shr)
  );

  // Operand magnitudes and signs for the request presented on the bus.
  always_comb begin
    start_signed = op_is_signed(bus.Op);
    a_neg        = start_signed & bus.A[WIDTH-1];
    b_neg        = start_signed & bus.B[WIDTH-1];
    abs_a        = a_neg ? -bus.A : bus.A;
    abs_b        = b_neg ? -bus.B : bus.B;
  end

  // Sign correction of the finished magnitudes (and accumulate when enabled).
  always_comb begin
    prod_mag = {acc_q, shr_q};
    prod_fix = neg_res_q ? -prod_mag : prod_mag;
    quot_fix = neg_res_q ? -shr_q : shr_q;
    rem_fix  = neg_rem_q ? -acc_q : acc_q;
`ifdef MULDIV_MADD_EN
    hilo_add = {hi_q, lo_q} + prod_fix;
    hilo_sub = {hi_q, lo_q} - prod_fix;
`endif
  end

  // Next-state, iteration and result-write logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    op_d      = op_q;
    acc_d     = acc_q;
    shr_d     = shr_q;
    opnd_d    = opnd_q;
    a_raw_d   = a_raw_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.Start) begin
          case (bus.Op)
            OP_MTHI: begin
              hi_d   = bus.A;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = bus.A;
              done_d = 1'b1;
            end
`ifndef MULDIV_MADD_EN
            OP_MADD, OP_MSUB: begin
              done_d = 1'b1;
            end
`endif
            default: begin
              state_d   = ST_CALC;
              busy_d    = 1'b1;
              cnt_d     = '0;
              op_d      = bus.Op;
              acc_d     = '0;
              // Divide shifts the dividend through shr; multiply shifts the multiplier.
              shr_d     = op_is_div(bus.Op) ? abs_a : abs_b;
              opnd_d    = op_is_div(bus.Op) ? abs_b : abs_a;
              a_raw_d   = bus.A;
              neg_res_d = a_neg ^ b_neg;
              neg_rem_d = a_neg;
              div0_d    = (bus.B == '0);
            end
          endcase
        end
      end
      ST_CALC: begin
        acc_d = step_acc;
        shr_d = step_shr;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        cnt_d   = '0;
        case (op_q)
          OP_DIV, OP_DIVU: begin
            // Divide by zero returns the raw dividend in HI and all-ones in LO.
            if (div0_q) begin
              hi_d = a_raw_q;
              lo_d = '1;
            end else begin
              hi_d = rem_fix;
              lo_d = quot_fix;
            end
          end
`ifdef MULDIV_MADD_EN
          OP_MADD: {hi_d, lo_d} = hilo_add;
          OP_MSUB: {hi_d, lo_d} = hilo_sub;
`endif
          default: {hi_d, lo_d} = prod_fix;
        endcase
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Control and architectural HI/LO registers; reset abandons any operation.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Working datapath registers; only meaningful while CALC/FIX, so no reset.
  always_ff @(posedge Clk) begin
    op_q      <= op_d;
    acc_q     <= acc_d;
    shr_q     <= shr_d;
    opnd_q    <= opnd_d;
    a_raw_q   <= a_raw_d;
    neg_res_q <= neg_res_d;
    neg_rem_q <= neg_rem_d;
    div0_q    <= div0_d;
  end

  assign bus.Busy   = busy_q;
  assign bus.Done   = done_q;
  assign bus.Hi_res = hi_q;
  assign bus.Lo_res = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed scenarios plus randomized
// operations checked against a plain-arithmetic HI/LO reference model.
module tb_mul_div_unit;

  localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3;
  localparam logic [2:0] MADD = 3'd4, MSUB = 3'd5, MTHI = 3'd6, MTLO = 3'd7;

  bit          clk = 1'b0;
  logic        rst_n;
  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] m_hi, m_lo;

  mul_div_unit_if #(.WIDTH(32)) bus ();

  mul_div_unit #(.WIDTH(32)) dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit madd_on();
`ifdef MULDIV_MADD_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Cycles from the Start edge to the Done edge.
  function automatic int exp_lat(input logic [2:0] op);
    if (op == MULT || op == MULTU || op == DIV || op == DIVU) return 33;
    if ((op == MADD || op == MSUB) && madd_on()) return 33;
    return 0;
  endfunction

  // Reference model of the architectural HI/LO pair.
  task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] hl, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hl = {m_hi, m_lo};
    p  = 64'(sa * sb);
    case (op)
      MULT:  hl = p;
      MULTU: hl = {32'd0, a} * {32'd0, b};
      DIV: begin
        if (b == 32'd0) hl = {a, 32'hFFFF_FFFF};
        else begin
          q  = sa / sb;
          r  = sa % sb;
          hl = {32'(r), 32'(q)};
        end
      end
      DIVU: begin
        if (b == 32'd0) hl = {a, 32'hFFFF_FFFF};
        else hl = {a % b, a / b};
      end
      MADD: if (madd_on()) hl = hl + p;
      MSUB: if (madd_on()) hl = hl - p;
      MTHI: hl[63:32] = a;
      MTLO: hl[31:0] = a;
      default: ;
    endcase
    {m_hi, m_lo} = hl;
  endtask

  // Drive one request now, optionally pulse a stray Start at edge inject_at,
  // and watch until Done (bounded). lat = -1 means Done never came.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int inject_at, output int lat, output logic [31:0] hi,
                        output logic [31:0] lo, output bit busy_ok, output bit stable);
    logic [31:0] hi0, lo0;
    hi0 = bus.Hi_res;
    lo0 = bus.Lo_res;
    lat = -1;
    busy_ok = 1'b1;
    stable = 1'b1;
    bus.Start = 1'b1;
    bus.Op = op;
    bus.A = a;
    bus.B = b;
    for (int k = 0; k <= 40 && lat < 0; k++) begin
      @(posedge clk);
      #1;
      bus.Start = (k + 1 == inject_at);
      if (k == 0) begin
        bus.A = $urandom;
        bus.B = $urandom;
        bus.Op = 3'($urandom_range(0, 7));
      end
      if (bus.Done === 1'b1) begin
        lat = k;
        if (bus.Busy !== 1'b0) busy_ok = 1'b0;
      end else begin
        if (bus.Busy !== 1'b1) busy_ok = 1'b0;
        if (bus.Hi_res !== hi0 || bus.Lo_res !== lo0) stable = 1'b0;
      end
    end
    bus.Start = 1'b0;
    hi = bus.Hi_res;
    lo = bus.Lo_res;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.Start = 1'b0;
    bus.Op = 3'd0;
    bus.A = 32'd0;
    bus.B = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (bus.Busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.Busy); else n_pass++;
    n_total++; if (bus.Done !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus.Done); else n_pass++;
    n_total++; if (bus.Hi_res !== 32'd0) $display("FAIL reset_hi: got %h expected 0", bus.Hi_res); else n_pass++;
    n_total++; if (bus.Lo_res !== 32'd0) $display("FAIL reset_lo: got %h expected 0", bus.Lo_res); else n_pass++;
    rst_n = 1'b1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
  endtask

  task automatic test_mult();
    int lat; logic [31:0] hi, lo; bit bok, st;
    model_apply(MULT, 32'hFFFF_FFFD, 32'd7);
    run_op(MULT, 32'hFFFF_FFFD, 32'd7, -1, lat, hi, lo, bok, st);
    n_total++; if (lat !== 33) $display("FAIL mult_latency: got %0d expected 33", lat); else n_pass++;
    n_total++; if (hi !== 32'hFFFF_FFFF) $display("FAIL mult_hi: got %h expected ffffffff", hi); else n_pass++;
    n_total++; if (lo !== 32'hFFFF_FFEB) $display("FAIL mult_lo: got %h expected ffffffeb", lo); else n_pass++;
    n_total++; if (!(bok && st)) $display("FAIL mult_busy_stable: got busy_ok=%0d stable=%0d expected 1 1", bok, st); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (bus.Done !== 1'b0) $display("FAIL mult_done_width: got %b expected 0", bus.Done); else n_pass++;
    n_total++; if (bus.Lo_res !== 32'hFFFF_FFEB) $display("FAIL mult_lo_hold: got %h expected ffffffeb", bus.Lo_res); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_multu_ignore_start();
    int lat; logic [31:0] hi, lo; bit bok, st;
    model_apply(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10, lat, hi, lo, bok, st);
    n_total++; if (lat !== 33) $display("FAIL multu_latency: got %0d expected 33", lat); else n_pass++;
    n_total++; if (hi !== 32'hFFFF_FFFE) $display("FAIL multu_hi: got %h expected fffffffe", hi); else n_pass++;
    n_total++; if (lo !== 32'h0000_0001) $display("FAIL multu_lo: got %h expected 00000001", lo); else n_pass++;
    n_total++; if (!(bok && st)) $display("FAIL multu_busy_stable: got busy_ok=%0d stable=%0d expected 1 1", bok, st); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) $display("FAIL multu_idle_after: got busy=%b done=%b expected 0 0", bus.Busy, bus.Done); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_div();
    int lat; logic [31:0] hi, lo; bit bok, st;
    model_apply(DIV, 32'hFFFF_FFF9, 32'd2);
    run_op(DIV, 32'hFFFF_FFF9, 32'd2, -1, lat, hi, lo, bok, st);
    n_total++; if (lat !== 33) $display("FAIL div_latency: got %0d expected 33", lat); else n_pass++;
    n_total++; if (lo !== 32'hFFFF_FFFD) $display("FAIL div_lo: got %h expected fffffffd", lo); else n_pass++;
    n_total++; if (hi !== 32'hFFFF_FFFF) $display("FAIL div_hi: got %h expected ffffffff", hi); else n_pass++;
    @(negedge clk);
    model_apply(DIVU, 32'h1234, 32'd0);
    run_op(DIVU, 32'h1234, 32'd0, -1, lat, hi, lo, bok, st);
    n_total++; if (lat !== 33) $display("FAIL divu0_latency: got %0d expected 33", lat); else n_pass++;
    n_total++; if (hi !== 32'h0000_1234) $display("FAIL divu0_hi: got %h expected 00001234", hi); else n_pass++;
    n_total++; if (lo !== 32'hFFFF_FFFF) $display("FAIL divu0_lo: got %h expected ffffffff", lo); else n_pass++;
    @(negedge clk);
    model_apply(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, lat, hi, lo, bok, st);
    n_total++; if (lo !== 32'h8000_0000) $display("FAIL div_ovf_lo: got %h expected 80000000", lo); else n_pass++;
    n_total++; if (hi !== 32'h0000_0000) $display("FAIL div_ovf_hi: got %h expected 00000000", hi); else n_pass++;
    n_total++; if (!(bok && st)) $display("FAIL div_busy_stable: got busy_ok=%0d stable=%0d expected 1 1", bok, st); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_madd_msub();
    int lat; logic [31:0] hi, lo; bit bok, st;
    model_apply(MTHI, 32'd0, 32'd0);
    run_op(MTHI, 32'd0, 32'd99, -1, lat, hi, lo, bok, st);
    n_total++; if (lat !== 0 || hi !== 32'd0) $display("FAIL mthi: got lat=%0d hi=%h expected lat=0 hi=0", lat, hi); else n_pass++;
    n_total++; if (!bok) $display("FAIL mthi_busy: got busy_ok=%0d expected 1", bok); else n_pass++;
    model_apply(MTLO, 32'h10, 32'd0);
    run_op(MTLO, 32'h10, 32'd5, -1, lat, hi, lo, bok, st);
    n_total++; if (lat !== 0 || lo !== 32'h10) $display("FAIL mtlo: got lat=%0d lo=%h expected lat=0 lo=10", lat, lo); else n_pass++;
    @(negedge clk);
    model_apply(MADD, 32'd3, 32'd4);
    run_op(MADD, 32'd3, 32'd4, -1, lat, hi, lo, bok, st);
`ifdef MULDIV_MADD_EN
    n_total++; if (lat !== 33) $display("FAIL madd_latency: got %0d expected 33", lat); else n_pass++;
    n_total++; if (lo !== 32'h1C || hi !== 32'd0) $display("FAIL madd_result: got %h_%h expected 00000000_0000001c", hi, lo); else n_pass++;
`else
    n_total++; if (lat !== 0) $display("FAIL madd_latency: got %0d expected 0", lat); else n_pass++;
    n_total++; if (lo !== 32'h10 || hi !== 32'd0) $display("FAIL madd_result: got %h_%h expected 00000000_00000010", hi, lo); else n_pass++;
`endif
    n_total++; if (!bok) $display("FAIL madd_busy: got busy_ok=%0d expected 1", bok); else n_pass++;
    @(negedge clk);
    model_apply(MSUB, 32'd3, 32'd10);
    run_op(MSUB, 32'd3, 32'd10, -1, lat, hi, lo, bok, st);
`ifdef MULDIV_MADD_EN
    n_total++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE) $display("FAIL msub_result: got %h_%h expected ffffffff_fffffffe", hi, lo); else n_pass++;
`else
    n_total++; if (hi !== 32'd0 || lo !== 32'h10) $display("FAIL msub_result: got %h_%h expected 00000000_00000010", hi, lo); else n_pass++;
`endif
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    int lat, ndone; logic [31:0] hi, lo; bit bok, st;
    model_apply(MULTU, 32'd5, 32'd6);
    run_op(MULTU, 32'd5, 32'd6, -1, lat, hi, lo, bok, st);
    n_total++; if (lo !== 32'd30 || hi !== 32'd0) $display("FAIL rst_pre_multu: got %h_%h expected 00000000_0000001e", hi, lo); else n_pass++;
    @(negedge clk);
    bus.Start = 1'b1; bus.Op = DIV; bus.A = 32'd100; bus.B = 32'd7;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_total++; if (bus.Busy !== 1'b0) $display("FAIL rst_mid_busy: got %b expected 0", bus.Busy); else n_pass++;
    n_total++; if (bus.Done !== 1'b0) $display("FAIL rst_mid_done: got %b expected 0", bus.Done); else n_pass++;
    n_total++; if (bus.Hi_res !== 32'd0 || bus.Lo_res !== 32'd0) $display("FAIL rst_mid_hilo: got %h_%h expected 0_0", bus.Hi_res, bus.Lo_res); else n_pass++;
    rst_n = 1'b1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) ndone++;
    end
    n_total++; if (ndone !== 0) $display("FAIL rst_mid_no_done: got %0d active cycles expected 0", ndone); else n_pass++;
    model_apply(MULTU, 32'd5, 32'd6);
    run_op(MULTU, 32'd5, 32'd6, -1, lat, hi, lo, bok, st);
    n_total++; if (lat !== 33) $display("FAIL rst_post_latency: got %0d expected 33", lat); else n_pass++;
    n_total++; if (lo !== 32'd30 || hi !== 32'd0) $display("FAIL rst_post_multu: got %h_%h expected 00000000_0000001e", hi, lo); else n_pass++;
    @(negedge clk);
  endtask

  // Each request is driven in the Done cycle of the previous one.
  task automatic test_back_to_back();
    int lat; logic [31:0] hi, lo; bit bok, st;
    logic [2:0]  ops [4];
    logic [31:0] as [4];
    logic [31:0] bs [4];
    ops[0] = MULT;  as[0] = 32'hFFFF_0000; bs[0] = 32'h0001_2345;
    ops[1] = DIVU;  as[1] = 32'hDEAD_BEEF; bs[1] = 32'h0000_0100;
    ops[2] = MTLO;  as[2] = 32'h5555_AAAA; bs[2] = 32'd0;
    ops[3] = DIV;   as[3] = 32'd17;        bs[3] = 32'hFFFF_FFFB;
    for (int i = 0; i < 4; i++) begin
      model_apply(ops[i], as[i], bs[i]);
      run_op(ops[i], as[i], bs[i], -1, lat, hi, lo, bok, st);
      n_total++; if (lat !== exp_lat(ops[i])) $display("FAIL b2b_latency[%0d]: got %0d expected %0d", i, lat, exp_lat(ops[i])); else n_pass++;
      n_total++; if (hi !== m_hi || lo !== m_lo) $display("FAIL b2b_result[%0d]: got %h_%h expected %h_%h", i, hi, lo, m_hi, m_lo); else n_pass++;
    end
    @(negedge clk);
  endtask

  task automatic test_random(input int n);
    int lat, el, sel; logic [2:0] op; logic [31:0] a, b, hi, lo; bit bok, st;
    for (int i = 0; i < n; i++) begin
      op  = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 4);
      a   = (sel == 0) ? 32'h8000_0000 : (sel == 1) ? 32'($urandom_range(0, 40)) : $urandom;
      sel = $urandom_range(0, 5);
      b   = (sel == 0) ? 32'd0 : (sel == 1) ? 32'hFFFF_FFFF : (sel == 2) ? 32'($urandom_range(1, 9)) : $urandom;
      el  = exp_lat(op);
      model_apply(op, a, b);
      run_op(op, a, b, (el > 0 && sel == 3) ? 20 : -1, lat, hi, lo, bok, st);
      n_total++; if (lat !== el) $display("FAIL rand_latency[%0d] op=%0d: got %0d expected %0d", i, op, lat, el); else n_pass++;
      n_total++; if (hi !== m_hi) $display("FAIL rand_hi[%0d] op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, hi, m_hi); else n_pass++;
      n_total++; if (lo !== m_lo) $display("FAIL rand_lo[%0d] op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, lo, m_lo); else n_pass++;
      n_total++; if (!(bok && st)) $display("FAIL rand_busy_stable[%0d]: got busy_ok=%0d stable=%0d expected 1 1", i, bok, st); else n_pass++;
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu_ignore_start();
    test_div();
    test_madd_msub();
    test_reset_mid_op();
    test_back_to_back();
    test_random(60);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
